// File: rtl/leaf_accum.sv
// Leaf-value accumulator: issues one leaf lookup per classifier result and sums
// the returned signed leaf values into a per-stage total for the threshold stage.
module leaf_accum #(
    parameter int unsigned W_LEAF         = 13,
    parameter int unsigned FEATURE_NUM    = 2913,
    parameter int unsigned MAX_STAGE_FEAT = 256,
    localparam int unsigned W_ADDR        = $clog2(FEATURE_NUM),
    localparam int unsigned W_CNT         = $clog2(MAX_STAGE_FEAT + 1),
    localparam int unsigned W_ACC         = W_LEAF + $clog2(MAX_STAGE_FEAT)
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [W_ADDR-1:0]        res_addr,
    input  logic                     res_leaf,
    input  logic                     res_last,

    output logic                     addr_valid,
    input  logic                     addr_ready,
    output logic [W_ADDR-1:0]        addr_data,
    output logic                     leaf_num,

    input  logic                     data_valid,
    output logic                     data_ready,
    input  logic signed [W_LEAF-1:0] data,

    output logic                     sum_valid,
    input  logic                     sum_ready,
    output logic signed [W_ACC-1:0]  sum_data,
    output logic [W_CNT-1:0]         sum_cnt
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_t;

    state_t                   state_q;
    logic [W_ADDR-1:0]        addr_q;
    logic                     leaf_q;
    logic                     last_q;
    logic signed [W_ACC-1:0]  acc_q;
    logic [W_CNT-1:0]         cnt_q;

    logic signed [W_ACC-1:0]  data_ext;
    logic [W_CNT-1:0]         cnt_inc;
    logic                     stage_full;

    assign data_ext   = {{(W_ACC - W_LEAF){data[W_LEAF-1]}}, data};
    assign cnt_inc    = cnt_q + W_CNT'(1);
    assign stage_full = (cnt_inc == W_CNT'(MAX_STAGE_FEAT));

    // addr_q/leaf_q only load in StIdle, so they stay frozen across StReq and StWait
    // while the responder steers its data path on leaf_num.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            leaf_q  <= 1'b0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (res_valid) begin
                        addr_q  <= res_addr;
                        leaf_q  <= res_leaf;
                        last_q  <= res_last;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (addr_ready) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (data_valid) begin
                        acc_q   <= acc_q + data_ext;
                        cnt_q   <= cnt_inc;
                        state_q <= (last_q || stage_full) ? StOut : StIdle;
                    end
                end
                StOut: begin
                    if (sum_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Handshake outputs are pure state decodes: no input reaches an output.
    assign res_ready  = (state_q == StIdle);
    assign addr_valid = (state_q == StReq);
    assign data_ready = (state_q == StWait);
    assign sum_valid  = (state_q == StOut);
    assign addr_data  = addr_q;
    assign leaf_num   = leaf_q;
    assign sum_data   = (state_q == StOut) ? acc_q : '0;
    assign sum_cnt    = (state_q == StOut) ? cnt_q : '0;

endmodule
